// File: rtl/mips_memctl.sv
// Memory controller between the multicycle mips core and exmem: wait states, posted write buffer, read stall.
// Latency: writes 0 cycles when the buffer has room; reads WAITS+3 cycles plus (WAITS+2) per buffered write.
// Backpressure: cpu_ready stays low on a write while the buffer is full and on a read until data returns.
//
// Parameters: WIDTH (data/address width), WAITS (0..15 idle cycles before each access),
//             WBDEPTH (write-buffer entries, power of 2, >= 2).
// Ports:  clk, reset (async, active low)
//         cpu_read/cpu_write/cpu_adr/cpu_wdata in, cpu_rdata/cpu_ready out (core side)
//         mem_en/mem_we/mem_adr/mem_wdata out, mem_rdata in (synchronous memory side)
// Optional build macro MIPS_MEMCTL_FWD_EN: reads that hit a buffered write are answered from the
// buffer (youngest matching entry) without touching memory.
module mips_memctl #(
    parameter int WIDTH   = 8,
    parameter int WAITS   = 1,
    parameter int WBDEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_ready,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int         PW      = $clog2(WBDEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAITS);
    localparam logic [PW:0] FULL   = WBDEPTH[PW:0];

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_ISSUE,
        RD_WAIT,
        RD_ISSUE,
        RD_DATA,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [PW-1:0]    head_q, tail_q;
    logic [PW:0]      count_q;
    logic [WIDTH-1:0] wb_adr_q [WBDEPTH];
    logic [WIDTH-1:0] wb_dat_q [WBDEPTH];

    logic             push;
    logic             pop;
    logic             rd_req;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_dat;

    // A write is accepted whenever there is room, regardless of what the drain FSM is doing.
    // Gating with reset keeps cpu_ready low while the block is held in reset.
    assign push   = cpu_write && (count_q != FULL) && reset;
    assign pop    = (state_q == WR_ISSUE);
    // A simultaneous read+write is a write; the read half is ignored.
    assign rd_req = cpu_read && !cpu_write;

`ifdef MIPS_MEMCTL_FWD_EN
    logic [PW-1:0] idx;

    // Walk valid entries oldest to youngest so the youngest match overrides older ones.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        idx     = '0;
        for (int k = 0; k < WBDEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((k < int'(count_q)) && (wb_adr_q[idx] == cpu_adr)) begin
                fwd_hit = 1'b1;
                fwd_dat = wb_dat_q[idx];
            end
        end
    end
`else
    assign fwd_hit = 1'b0;
    assign fwd_dat = '0;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (rd_req && fwd_hit) begin
                    rdata_d = fwd_dat;
                    state_d = DONE;
                end else if (count_q != '0) begin
                    // Buffered writes always go to memory before any read so order is kept.
                    if (WAITS == 0) begin
                        state_d = WR_ISSUE;
                    end else begin
                        state_d = WR_WAIT;
                        wcnt_d  = WAIT_LD;
                    end
                end else if (rd_req) begin
                    if (WAITS == 0) begin
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = RD_WAIT;
                        wcnt_d  = WAIT_LD;
                    end
                end
            end
            WR_WAIT: begin
                if (wcnt_q == 4'd1) begin
                    state_d = WR_ISSUE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            WR_ISSUE: state_d = IDLE;
            RD_WAIT: begin
                if (wcnt_q == 4'd1) begin
                    state_d = RD_ISSUE;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA: begin
                // Synchronous memory: data for the RD_ISSUE strobe is present now.
                rdata_d = mem_rdata;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes decode purely from state; everything is zero outside the issue states.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        case (state_q)
            WR_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_adr   = wb_adr_q[head_q];
                mem_wdata = wb_dat_q[head_q];
            end
            RD_ISSUE: begin
                mem_en  = 1'b1;
                mem_adr = cpu_adr;
            end
            default: ;
        endcase
    end

    assign cpu_ready = push || (state_q == DONE);
    assign cpu_rdata = rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rdata_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: validity is tracked by count/head.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_adr_q[tail_q] <= cpu_adr;
            wb_dat_q[tail_q] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_mips_memctl.sv
module tb_mips_memctl;

    localparam int WIDTH   = 8;
    localparam int WAITS   = 1;
    localparam int WBDEPTH = 2;

    localparam int OP_IDLE  = 0;
    localparam int OP_DRAIN = 1;
    localparam int OP_READ  = 2;
    localparam int OP_FWD   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_read;
    logic       cpu_write;
    logic [7:0] cpu_adr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       cpu_ready;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_adr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    mips_memctl #(
        .WIDTH  (WIDTH),
        .WAITS  (WAITS),
        .WBDEPTH(WBDEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_read (cpu_read),
        .cpu_write(cpu_write),
        .cpu_adr  (cpu_adr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-up memory image shared by the bench memory and the reference memory.
    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    // Synchronous memory attached to the DUT.
    logic [7:0] mem_val [256];
    bit         mem_vld [256];
    logic [7:0] wr_log [$];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_val[mem_adr] <= mem_wdata;
            mem_vld[mem_adr] <= 1'b1;
            wr_log.push_back(mem_adr);
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= mem_vld[mem_adr] ? mem_val[mem_adr] : init_val(mem_adr);
        end
    end

    function automatic logic [7:0] mem_rd(input logic [7:0] a);
        return mem_vld[a] ? mem_val[a] : init_val(a);
    endfunction

    // Reference model: transaction timeline (what the controller is busy with and for how long).
    logic [7:0] wb_a [$];
    logic [7:0] wb_d [$];
    int         op = OP_IDLE;
    int         t = 0;
    logic [7:0] m_rdata = 8'h00;
    logic [7:0] fwd_dat = 8'h00;
    bit         ref_vld [256];
    logic [7:0] ref_val [256];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    function automatic logic [7:0] ref_rd(input logic [7:0] a);
        return ref_vld[a] ? ref_val[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called once per cycle at the falling edge: compares outputs, then advances the model.
    task automatic model_cycle();
        logic       wr_acc, rd, hit, e_rdy, e_en, e_we;
        logic [7:0] e_adr, e_wd, hd;
        cyc++;
        if (!reset) begin
            chk("rst_cpu_ready", 32'(cpu_ready), 0);
            chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_adr", 32'(mem_adr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            wb_a.delete();
            wb_d.delete();
            op      = OP_IDLE;
            t       = 0;
            m_rdata = 8'h00;
            return;
        end
        wr_acc = cpu_write && (wb_a.size() < WBDEPTH);
        rd     = cpu_read && !cpu_write;
        if (op == OP_IDLE) begin
            hit = 1'b0;
            hd  = 8'h00;
`ifdef MIPS_MEMCTL_FWD_EN
            foreach (wb_a[k]) begin
                if (wb_a[k] == cpu_adr) begin
                    hit = 1'b1;
                    hd  = wb_d[k];
                end
            end
`endif
            t = 0;
            if (rd && hit) begin
                op      = OP_FWD;
                fwd_dat = hd;
            end else if (wb_a.size() > 0) begin
                op = OP_DRAIN;
            end else if (rd) begin
                op = OP_READ;
            end
        end
        e_rdy = 1'b0; e_en = 1'b0; e_we = 1'b0; e_adr = 8'h00; e_wd = 8'h00;
        if (op == OP_DRAIN && t == WAITS + 1) begin
            e_en = 1'b1; e_we = 1'b1; e_adr = wb_a[0]; e_wd = wb_d[0];
        end
        if (op == OP_READ && t == WAITS + 1) begin
            e_en = 1'b1; e_adr = cpu_adr;
        end
        if (op == OP_READ && t == WAITS + 3) e_rdy = 1'b1;
        if (op == OP_FWD && t == 1) e_rdy = 1'b1;
        e_rdy = e_rdy | wr_acc;

        chk("cpu_ready", 32'(cpu_ready), 32'(e_rdy));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_adr", 32'(mem_adr), 32'(e_adr));
        if (!(e_en && !e_we)) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));

        case (op)
            OP_DRAIN: begin
                if (t == WAITS + 1) begin
                    ref_val[wb_a[0]] = wb_d[0];
                    ref_vld[wb_a[0]] = 1'b1;
                    void'(wb_a.pop_front());
                    void'(wb_d.pop_front());
                    op = OP_IDLE;
                end else begin
                    t++;
                end
            end
            OP_READ: begin
                if (t == WAITS + 2) m_rdata = ref_rd(cpu_adr);
                if (t == WAITS + 3) op = OP_IDLE;
                else t++;
            end
            OP_FWD: begin
                if (t == 0) m_rdata = fwd_dat;
                if (t == 1) op = OP_IDLE;
                else t++;
            end
            default: ;
        endcase
        if (wr_acc) begin
            wb_a.push_back(cpu_adr);
            wb_d.push_back(cpu_wdata);
        end
    endtask

    task automatic idle_watch(input int n, output int strobes);
        strobes = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            model_cycle();
            if (mem_en) strobes++;
            @(posedge clk);
            #1;
        end
    endtask

    // One core request, held until cpu_ready; offsets count the request cycle as 0.
    task automatic req(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rdat, output int rd_off,
                       output int wr_off, output int n_rd);
        cpu_read  = r;
        cpu_write = w;
        cpu_adr   = a;
        cpu_wdata = d;
        lat = -1; rd_off = -1; wr_off = -1; n_rd = 0; rdat = 8'h00;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            model_cycle();
            if (mem_en && !mem_we) begin
                n_rd++;
                if (rd_off < 0) rd_off = k;
            end
            if (mem_en && mem_we && wr_off < 0) wr_off = k;
            if (cpu_ready) begin
                lat  = k;
                rdat = cpu_rdata;
            end
            @(posedge clk);
            #1;
            if (lat >= 0) break;
        end
        if (lat < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: cpu_ready not seen in 200 cycles, required within 200 (cycle %0d)", cyc);
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, ro, wo, nr, base, gap, kind;
        logic [7:0] rdat, a;
        logic       r, w;

        reset     = 1'b1;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        cpu_adr   = 8'h10;
        cpu_wdata = 8'h00;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a read request pending: everything stays at zero.
        idle_watch(3, nr);
        cpu_read = 1'b0;
        reset    = 1'b1;
        idle_watch(6, nr);
        chk("idle_no_strobe", nr, 0);

        // Single read from the empty buffer.
        req(1'b1, 1'b0, 8'h10, 8'h00, lat, rdat, ro, wo, nr);
        chk("rd_latency", lat, 4);
        chk("rd_strobe_cycle", ro, 2);
        chk("rd_strobe_count", nr, 1);
        chk("rd_data", 32'(rdat), 'hA5);
        idle_watch(4, nr);

        // Three back-to-back posted writes into a two-entry buffer.
        base = wr_log.size();
        req(1'b0, 1'b1, 8'h20, 8'h11, lat, rdat, ro, wo, nr);
        chk("wr1_latency", lat, 0);
        req(1'b0, 1'b1, 8'h21, 8'h22, lat, rdat, ro, wo, nr);
        chk("wr2_latency", lat, 0);
        req(1'b0, 1'b1, 8'h22, 8'h33, lat, rdat, ro, wo, nr);
        chk("wr3_stall", lat, 2);
        idle_watch(12, nr);
        chk("wr_log_count", wr_log.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < wr_log.size()) chk("wr_order", 32'(wr_log[base + i]), 'h20 + i);
        end
        chk("mem_20", 32'(mem_rd(8'h20)), 'h11);
        chk("mem_21", 32'(mem_rd(8'h21)), 'h22);
        chk("mem_22", 32'(mem_rd(8'h22)), 'h33);

        // Write immediately followed by a read of the same address.
        req(1'b0, 1'b1, 8'h30, 8'h5C, lat, rdat, ro, wo, nr);
        chk("ord_wr_latency", lat, 0);
        req(1'b1, 1'b0, 8'h30, 8'h00, lat, rdat, ro, wo, nr);
`ifdef MIPS_MEMCTL_FWD_EN
        chk("ord_fwd_latency", lat, 1);
        chk("ord_fwd_no_read", nr, 0);
`else
        chk("ord_rd_latency", lat, 7);
        chk("ord_wr_strobe", wo, 2);
        chk("ord_rd_strobe", ro, 5);
`endif
        chk("ord_rd_data", 32'(rdat), 'h5C);
        idle_watch(8, nr);

        // Two writes to one address, then a read of it.
        req(1'b0, 1'b1, 8'h40, 8'h01, lat, rdat, ro, wo, nr);
        req(1'b0, 1'b1, 8'h40, 8'h02, lat, rdat, ro, wo, nr);
        req(1'b1, 1'b0, 8'h40, 8'h00, lat, rdat, ro, wo, nr);
`ifdef MIPS_MEMCTL_FWD_EN
        chk("fwd_latency", lat, 3);
        chk("fwd_no_read", nr, 0);
`else
        chk("dup_latency", lat, 9);
        chk("dup_rd_strobe", ro, 7);
`endif
        chk("dup_rd_data", 32'(rdat), 'h02);
        idle_watch(8, nr);

        // Reset while the first of two buffered writes waits to issue.
        req(1'b0, 1'b1, 8'h60, 8'hAA, lat, rdat, ro, wo, nr);
        req(1'b0, 1'b1, 8'h61, 8'hBB, lat, rdat, ro, wo, nr);
        reset = 1'b0;
        idle_watch(2, nr);
        reset = 1'b1;
        idle_watch(8, nr);
        chk("rst_drain_no_strobe", nr, 0);
        chk("rst_mem_60", 32'(mem_rd(8'h60)), 'h3A);
        chk("rst_mem_61", 32'(mem_rd(8'h61)), 'h3B);
        req(1'b1, 1'b0, 8'h60, 8'h00, lat, rdat, ro, wo, nr);
        chk("rst_rd_latency", lat, 4);
        chk("rst_rd_60", 32'(rdat), 'h3A);
        req(1'b1, 1'b0, 8'h61, 8'h00, lat, rdat, ro, wo, nr);
        chk("rst_rd_61", 32'(rdat), 'h3B);

        // Randomized traffic concentrated on a few addresses.
        for (int n = 0; n < 400; n++) begin
            gap = int'($urandom_range(0, 3));
            if (gap > 0) idle_watch(gap, nr);
            kind = int'($urandom_range(0, 19));
            r = (kind < 9) || (kind >= 18);
            w = (kind >= 9);
            if ($urandom_range(0, 3) == 0) a = 8'($urandom);
            else a = 8'h80 + 8'($urandom_range(0, 3));
            req(r, w, a, 8'($urandom), lat, rdat, ro, wo, nr);
        end
        idle_watch(20, nr);

        for (int i = 0; i < 256; i++) begin
            chk("final_mem", 32'(mem_rd(8'(i))), 32'(ref_rd(8'(i))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
